// File: rtl/secuenciador_alerta.sv
// ---------------------------------------------------------------------------
// secuenciador_alerta
//
// Purpose:
//   Classifies gas-concentration samples into none / weak / strong alert
//   levels. Classification uses hysteresis below each threshold and an
//   N-sample debounce. A small sequencing FSM then does the following:
//     - strobes the downstream activation logic (Enable);
//     - reads its Danger feedback one cycle later;
//     - decides when to commit actuator outputs (Enable_Activacion).
//   A sample-timeout watchdog forces a fail-safe strong alert.
//
// Parameters:
//   W             sample width (unsigned)
//   UMBRAL_DEBIL  weak-alert threshold
//   UMBRAL_FUERTE strong-alert threshold, must exceed UMBRAL_DEBIL + HIST
//   HIST          hysteresis band below each threshold (no underflow allowed)
//   N_CONF        consecutive agreeing samples to change level (>= 1)
//   ACT_DIV       commit every ACT_DIV-th evaluation while Danger = 0 (>= 1)
//   TIMEOUT       idle cycles without a sample before fault (>= 2)
//
// Ports:
//   clk                in  clock, rising edge
//   rst                in  synchronous active-high reset
//   Dato               in  sensor sample (W bits)
//   Dato_Valido        in  sample qualifier, only looked at while idle
//   Danger             in  feedback from the activation logic
//   Alerta             out 00 none, 10 weak, 11 strong (registered)
//   Enable             out one-cycle evaluation strobe
//   Enable_Activacion  out one-cycle output-commit strobe
//   Falla              out sensor timeout fault
//   Ocupado            out high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module secuenciador_alerta #(
  parameter int W             = 8,
  parameter int UMBRAL_DEBIL  = 80,
  parameter int UMBRAL_FUERTE = 160,
  parameter int HIST          = 8,
  parameter int N_CONF        = 3,
  parameter int ACT_DIV       = 4,
  parameter int TIMEOUT       = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] Dato,
  input  logic         Dato_Valido,
  input  logic         Danger,
  output logic [1:0]   Alerta,
  output logic         Enable,
  output logic         Enable_Activacion,
  output logic         Falla,
  output logic         Ocupado
);

  // Thresholds and their hysteresis-lowered copies, resolved at elaboration.
  localparam logic [W-1:0] TH_F    = W'(UMBRAL_FUERTE);
  localparam logic [W-1:0] TH_F_LO = W'(UMBRAL_FUERTE - HIST);
  localparam logic [W-1:0] TH_D    = W'(UMBRAL_DEBIL);
  localparam logic [W-1:0] TH_D_LO = W'(UMBRAL_DEBIL - HIST);

  localparam int KW = $clog2(N_CONF + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = (ACT_DIV > 1) ? $clog2(ACT_DIV) : 1;

  localparam logic [KW-1:0] K_CONF = KW'(N_CONF);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [EW-1:0] E_LAST = EW'(ACT_DIV - 1);

  typedef enum logic [2:0] {
    ESPERA     = 3'd0,
    CLASIFICA  = 3'd1,
    EVALUA     = 3'd2,
    LEE_DANGER = 3'd3,
    ACTIVA     = 3'd4
  } estado_t;

  estado_t       state_q;
  logic [W-1:0]  dato_q;
  logic [1:0]    lvl_q,  lvl_d;
  logic [1:0]    cand_q, cand_d;
  logic [KW-1:0] k_q,    k_d;
  logic [TW-1:0] t_q;
  logic [EW-1:0] e_q,    e_inc;
  logic [1:0]    alerta_q;
  logic          en_q, ea_q, falla_q, ocup_q;

  logic [1:0]    tgt;
  logic [KW-1:0] k_nxt;

  // Level code 0/1/2 -> output alert code. 01 is never produced.
  function automatic logic [1:0] enc(input logic [1:0] l);
    case (l)
      2'd2:    enc = 2'b11;
      2'd1:    enc = 2'b10;
      default: enc = 2'b00;
    endcase
  endfunction

  // Target level. The lowered thresholds only apply to holding the level
  // already in force, which is what gives the hysteresis band.
  always_comb begin
    tgt = 2'd0;
    if (dato_q >= TH_F)                         tgt = 2'd2;
    else if (lvl_q == 2'd2 && dato_q >= TH_F_LO) tgt = 2'd2;
    else if (dato_q >= TH_D)                    tgt = 2'd1;
    else if (lvl_q != 2'd0 && dato_q >= TH_D_LO) tgt = 2'd1;
  end

  // Debounce: any sample agreeing with the current level clears the
  // streak. A target that differs from the candidate restarts the streak
  // at 1.
  always_comb begin
    cand_d = cand_q;
    k_d    = k_q;
    lvl_d  = lvl_q;
    k_nxt  = k_q;
    if (tgt == lvl_q) begin
      k_d = '0;
    end else begin
      if (tgt == cand_q) begin
        k_nxt = k_q + KW'(1);
      end else begin
        cand_d = tgt;
        k_nxt  = KW'(1);
      end
      if (k_nxt == K_CONF) begin
        lvl_d = tgt;
        k_d   = '0;
      end else begin
        k_d = k_nxt;
      end
    end
  end

  // Evaluation counter, modulo ACT_DIV. With ACT_DIV = 1 it always wraps.
  assign e_inc = (e_q == E_LAST) ? '0 : e_q + EW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ESPERA;
      dato_q   <= '0;
      lvl_q    <= 2'd0;
      cand_q   <= 2'd0;
      k_q      <= '0;
      t_q      <= '0;
      e_q      <= '0;
      alerta_q <= 2'b00;
      en_q     <= 1'b0;
      ea_q     <= 1'b0;
      falla_q  <= 1'b0;
      ocup_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle; only the transitions below raise them.
      en_q <= 1'b0;
      ea_q <= 1'b0;
      case (state_q)
        ESPERA: begin
          // A sample wins over a timeout that expires in the same cycle.
          if (Dato_Valido) begin
            dato_q  <= Dato;
            t_q     <= '0;
            ocup_q  <= 1'b1;
            state_q <= CLASIFICA;
          end else if (t_q == T_LAST) begin
            // Fail-safe: force strong and evaluate without a sample.
            // The candidate is left alone; only the streak restarts.
            falla_q  <= 1'b1;
            lvl_q    <= 2'd2;
            k_q      <= '0;
            t_q      <= '0;
            alerta_q <= 2'b11;
            en_q     <= 1'b1;
            ocup_q   <= 1'b1;
            state_q  <= EVALUA;
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        CLASIFICA: begin
          lvl_q    <= lvl_d;
          cand_q   <= cand_d;
          k_q      <= k_d;
          alerta_q <= enc(lvl_d);
          falla_q  <= 1'b0;
          en_q     <= 1'b1;
          state_q  <= EVALUA;
        end
        EVALUA: begin
          state_q <= LEE_DANGER;
        end
        LEE_DANGER: begin
          // Activations commit at once and restart the divider. With
          // Danger low, a commit happens only when the divider wraps.
          if (Danger) begin
            e_q     <= '0;
            ea_q    <= 1'b1;
            state_q <= ACTIVA;
          end else begin
            e_q <= e_inc;
            if (e_inc == '0) begin
              ea_q    <= 1'b1;
              state_q <= ACTIVA;
            end else begin
              ocup_q  <= 1'b0;
              state_q <= ESPERA;
            end
          end
        end
        ACTIVA: begin
          ocup_q  <= 1'b0;
          state_q <= ESPERA;
        end
        default: begin
          ocup_q  <= 1'b0;
          state_q <= ESPERA;
        end
      endcase
    end
  end

  assign Alerta            = alerta_q;
  assign Enable            = en_q;
  assign Enable_Activacion = ea_q;
  assign Falla             = falla_q;
  assign Ocupado           = ocup_q;

endmodule

// File: tb/tb_secuenciador_alerta.sv
// ---------------------------------------------------------------------------
// tb_secuenciador_alerta
//
// Directed bench for secuenciador_alerta using the default parameters.
// Outputs are sampled on the falling edge. Each sample transaction
// records the following:
//   - the cycle offset (1..5 after acceptance) of Enable;
//   - the cycle offset of Enable_Activacion;
//   - the Alerta value seen in the Enable cycle.
// ---------------------------------------------------------------------------
module tb_secuenciador_alerta;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Dato;
  logic       Dato_Valido;
  logic       Danger;
  logic [1:0] Alerta;
  logic       Enable;
  logic       Enable_Activacion;
  logic       Falla;
  logic       Ocupado;

  int n_chk  = 0;
  int n_fail = 0;
  int n_en   = 0;
  int n_both = 0;

  secuenciador_alerta dut (
    .clk               (clk),
    .rst               (rst),
    .Dato              (Dato),
    .Dato_Valido       (Dato_Valido),
    .Danger            (Danger),
    .Alerta            (Alerta),
    .Enable            (Enable),
    .Enable_Activacion (Enable_Activacion),
    .Falla             (Falla),
    .Ocupado           (Ocupado)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Enable) n_en++;
    if (Enable && Enable_Activacion) n_both++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sample transaction. Optionally pulses Dato_Valido (with a
  // strong value) during the Enable cycle; the FSM must ignore it.
  task automatic muestra(input logic [7:0] d, input logic dng, input bit glitch,
                         output int en_at, output int ea_at,
                         output logic [1:0] al, output logic oc);
    @(negedge clk);
    Dato = d; Dato_Valido = 1'b1; Danger = dng;
    en_at = 0; ea_at = 0; al = 2'b00; oc = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      Dato_Valido = (glitch && i == 2);
      if (glitch && i == 2) Dato = 8'd200;
      if (Enable) en_at = i;
      if (Enable_Activacion) ea_at = i;
      if (i == 1) oc = Ocupado;
      if (i == 2) al = Alerta;
    end
    Dato_Valido = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int en_at, ea_at, ea_cnt, en0, cnt;
    logic [1:0] al;
    logic oc;
    bit saw_ea;
    logic [7:0] deb_v [6];
    logic [1:0] deb_e [6];
    deb_v = '{8'd90, 8'd90, 8'd40, 8'd90, 8'd90, 8'd90};
    deb_e = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};

    rst = 1'b1; Dato = '0; Dato_Valido = 1'b0; Danger = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_alerta", Alerta, 0);
    chk("rst_enable", Enable, 0);
    chk("rst_enact",  Enable_Activacion, 0);
    chk("rst_falla",  Falla, 0);
    chk("rst_ocupado", Ocupado, 0);

    // Rise to strong: 170 x3 -> 00, 00, 11. Danger=1 on the third.
    muestra(8'd170, 1'b0, 1'b0, en_at, ea_at, al, oc);
    chk("rise1_alerta", al, 0);
    chk("rise1_enact_none", ea_at, 0);
    chk("rise1_ocupado", oc, 1);
    muestra(8'd170, 1'b0, 1'b0, en_at, ea_at, al, oc);
    chk("rise2_alerta", al, 0);
    muestra(8'd170, 1'b1, 1'b0, en_at, ea_at, al, oc);
    chk("rise3_alerta", al, 3);
    chk("rise3_enable_at", en_at, 2);
    chk("rise3_enact_at", ea_at, 4);

    // Hysteresis: 155 holds strong; 150 x3 drops to weak.
    for (int i = 0; i < 5; i++) begin
      muestra(8'd155, 1'b1, 1'b0, en_at, ea_at, al, oc);
      chk($sformatf("hyst155_%0d", i), al, 3);
    end
    muestra(8'd150, 1'b1, 1'b0, en_at, ea_at, al, oc);
    chk("hyst150_1", al, 3);
    muestra(8'd150, 1'b1, 1'b0, en_at, ea_at, al, oc);
    chk("hyst150_2", al, 3);
    muestra(8'd150, 1'b1, 1'b0, en_at, ea_at, al, oc);
    chk("hyst150_3", al, 2);

    // Debounce restart: 90,90,40,90,90,90 from L=0 -> weak only on sixth.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      muestra(deb_v[i], 1'b0, 1'b0, en_at, ea_at, al, oc);
      chk($sformatf("deb_%0d", i), al, deb_e[i]);
    end

    // Rate limit: 8 evaluations with Danger=0 -> 2 commits. A stray
    // Dato_Valido during the third transaction must be ignored.
    ea_cnt = 0;
    en0 = n_en;
    for (int i = 0; i < 8; i++) begin
      muestra(8'd90, 1'b0, (i == 2), en_at, ea_at, al, oc);
      if (ea_at != 0) ea_cnt++;
    end
    repeat (3) @(negedge clk);
    chk("rate_enact_count", ea_cnt, 2);
    chk("rate_enable_count", n_en - en0, 8);
    chk("rate_alerta", Alerta, 2);
    chk("rate_ocupado_idle", Ocupado, 0);
    chk("strobes_exclusive", n_both, 0);

    // Watchdog: 1000 idle cycles after reset -> fault and strong alert.
    Danger = 1'b0;
    do_reset();
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!Falla && cnt < 1100);
    chk("wd_cycles", cnt, 1000);
    chk("wd_falla", Falla, 1);
    chk("wd_alerta", Alerta, 3);
    chk("wd_enable", Enable, 1);
    repeat (3) @(negedge clk);
    muestra(8'd10, 1'b0, 1'b0, en_at, ea_at, al, oc);
    chk("wd_clear_falla", Falla, 0);
    chk("wd_hold_alerta", al, 3);

    // Reset asserted while in LEE_DANGER: no commit strobe afterwards.
    @(negedge clk);
    Dato = 8'd170; Dato_Valido = 1'b1; Danger = 1'b1;
    @(negedge clk); Dato_Valido = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    saw_ea = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (Enable_Activacion) saw_ea = 1'b1;
    end
    rst = 1'b0;
    chk("rstmid_enact", saw_ea, 0);
    chk("rstmid_alerta", Alerta, 0);
    chk("rstmid_ocupado", Ocupado, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
